// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Purpose  : Configurable UART receiver (data width, parity, stop bits) with
//            majority-vote sampling, glitch rejection and error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);
    localparam int c_baud_cnt_max = CLK_FREQ / UART_BPS;
    localparam int c_cnt_w        = $clog2(c_baud_cnt_max);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_baud_cnt_max - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_samp0    = c_cnt_w'(c_baud_cnt_max / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_samp1    = c_cnt_w'(c_baud_cnt_max / 2);
    localparam logic [c_cnt_w-1:0] c_decide   = c_cnt_w'(c_baud_cnt_max / 2 + 1);
    localparam logic [3:0]         c_last_data = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_last_stop = 4'(STOP_BITS - 1);
    localparam logic               c_odd       = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_sync;
    logic [1:0]             r_fill;
    logic                   r_rxd_prev;
    logic [c_cnt_w-1:0]     r_baud_cnt;
    logic [1:0]             r_samp;
    logic [3:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr_l;
    logic                   r_ferr_l;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_valid;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   w_rxd_s;
    logic                   w_fall;
    logic                   w_bit;
    logic                   w_decide;
    logic                   w_frame_bad;

    // The edge-history flop only takes real line samples once the synchroniser
    // has flushed its reset value, so a line held low at reset is not a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync     <= 2'b11;
            r_fill     <= 2'b00;
            r_rxd_prev <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], uart_rxd};
            r_fill     <= {r_fill[0], 1'b1};
            r_rxd_prev <= r_sync[1] & r_fill[1];
        end
    end

    assign w_rxd_s     = r_sync[1];
    assign w_fall      = r_rxd_prev & ~w_rxd_s;
    assign w_bit       = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rxd_s) | (r_samp[1] & w_rxd_s);
    assign w_decide    = (r_baud_cnt == c_decide) &&
                         (r_state == S_START || r_state == S_DATA ||
                          r_state == S_PARITY || r_state == S_STOP);
    assign w_frame_bad = r_ferr_l | ~w_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_fall) w_state_next = S_START;
            S_START:     if (w_decide) w_state_next = w_bit ? S_IDLE : S_DATA;
            S_DATA:      if (w_decide && r_bit_cnt == c_last_data)
                             w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (w_decide) w_state_next = S_STOP;
            S_STOP:      if (w_decide && r_bit_cnt == c_last_stop)
                             w_state_next = w_frame_bad ? S_WAIT_HIGH : S_IDLE;
            S_WAIT_HIGH: if (w_rxd_s) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_samp     <= 2'b00;
            r_bit_cnt  <= 4'd0;
            r_shift    <= '0;
            r_perr_l   <= 1'b0;
            r_ferr_l   <= 1'b0;
            r_rx_data  <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;

            if (r_state == S_IDLE || r_state == S_WAIT_HIGH) r_baud_cnt <= '0;
            else if (r_baud_cnt == c_cnt_last)                r_baud_cnt <= '0;
            else                                              r_baud_cnt <= r_baud_cnt + c_cnt_one;

            if (r_baud_cnt == c_samp0) r_samp[0] <= w_rxd_s;
            if (r_baud_cnt == c_samp1) r_samp[1] <= w_rxd_s;

            // Per-frame bookkeeping restarts from IDLE, which always precedes START.
            if (r_state == S_IDLE) begin
                r_bit_cnt <= 4'd0;
                r_perr_l  <= 1'b0;
                r_ferr_l  <= 1'b0;
            end

            if (w_decide) begin
                case (r_state)
                    S_DATA: begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= (r_bit_cnt == c_last_data) ? 4'd0 : r_bit_cnt + 4'd1;
                    end
                    S_PARITY: r_perr_l <= ((^r_shift) ^ w_bit) != c_odd;
                    S_STOP: begin
                        if (r_bit_cnt == c_last_stop) begin
                            r_valid   <= 1'b1;
                            r_rx_data <= r_shift;
                            r_perr    <= r_perr_l;
                            r_ferr    <= w_frame_bad;
                            r_bit_cnt <= 4'd0;
                        end else begin
                            r_ferr_l  <= w_frame_bad;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign rx_busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Purpose  : Self-checking bench for uart_rx_cfg in three configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;
    localparam int c_clk_freq = 1_000_000;
    localparam int c_bps      = 100_000;
    localparam int c_bit      = c_clk_freq / c_bps;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rxd;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, b0, b1, b2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_valid0 = 0;
    int t_drop   = 0;
    // Event layout: [10] parity_err, [9] frame_err, [8:0] data
    logic [10:0] q0[$], q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLK_FREQ(c_clk_freq), .UART_BPS(c_bps)) u_dut0 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[0]), .rx_data(d0), .rx_valid(v0),
        .parity_err(pe0), .frame_err(fe0), .rx_busy(b0));
    uart_rx_cfg #(.CLK_FREQ(c_clk_freq), .UART_BPS(c_bps), .PARITY(2)) u_dut1 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[1]), .rx_data(d1), .rx_valid(v1),
        .parity_err(pe1), .frame_err(fe1), .rx_busy(b1));
    uart_rx_cfg #(.CLK_FREQ(c_clk_freq), .UART_BPS(c_bps), .DATA_BITS(7),
                  .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[2]), .rx_data(d2), .rx_valid(v2),
        .parity_err(pe2), .frame_err(fe2), .rx_busy(b2));

    always @(negedge clk) begin
        if (v0) begin q0.push_back({pe0, fe0, 1'b0, d0}); last_valid0 = cyc; end
        if (v1) q1.push_back({pe1, fe1, 1'b0, d1});
        if (v2) q2.push_back({pe2, fe2, 2'b00, d2});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Reference model: frame fields in, expected {parity_err, frame_err, data} out
    function automatic logic ones_parity(input logic [8:0] data, input int nbits);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ data[i];
        return p;
    endfunction

    function automatic logic good_par(input logic [8:0] data, input int nbits, input int pmode);
        if (pmode == 1) return ~ones_parity(data, nbits);
        return ones_parity(data, nbits);
    endfunction

    function automatic logic [10:0] model(input logic [8:0] data, input int nbits, input int pmode,
                                          input logic pbit, input logic [1:0] stops, input int nstop);
        logic [8:0] m;
        logic perr, ferr;
        m = data & ((9'd1 << nbits) - 9'd1);
        if (pmode == 0)      perr = 1'b0;
        else if (pmode == 1) perr = ((ones_parity(m, nbits) ^ pbit) != 1'b1);
        else                 perr = ((ones_parity(m, nbits) ^ pbit) != 1'b0);
        ferr = 1'b0;
        for (int i = 0; i < nstop; i++) if (!stops[i]) ferr = 1'b1;
        return {perr, ferr, m};
    endfunction

    task automatic drive(input int which, input logic v);
        rxd[which] = v;
    endtask

    task automatic bit_wait();
        repeat (c_bit) @(negedge clk);
    endtask

    task automatic idle_bits(input int which, input int n);
        drive(which, 1'b1);
        repeat (n) bit_wait();
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits, input int pmode,
                              input logic pbit, input logic [1:0] stops, input int nstop);
        t_drop = cyc;
        drive(which, 1'b0); bit_wait();
        for (int i = 0; i < nbits; i++) begin drive(which, data[i]); bit_wait(); end
        if (pmode != 0) begin drive(which, pbit); bit_wait(); end
        for (int i = 0; i < nstop; i++) begin drive(which, stops[i]); bit_wait(); end
    endtask

    function automatic int q_size(input int which);
        if (which == 0) return q0.size();
        if (which == 1) return q1.size();
        return q2.size();
    endfunction

    task automatic pop_ev(input int which, output logic [10:0] ev);
        ev = 'x;
        if (which == 0 && q0.size() > 0) ev = q0.pop_front();
        if (which == 1 && q1.size() > 0) ev = q1.pop_front();
        if (which == 2 && q2.size() > 0) ev = q2.pop_front();
    endtask

    task automatic clear_q(input int which);
        if (which == 0) q0.delete();
        if (which == 1) q1.delete();
        if (which == 2) q2.delete();
    endtask

    task automatic test_reset();
        n_checks++;
        if ({v0, pe0, fe0, b0, d0} !== 12'h000) begin
            n_fail++; $display("FAIL reset_dut0: got %h required 000", {v0, pe0, fe0, b0, d0});
        end
        n_checks++;
        if ({v1, pe1, fe1, b1, d1} !== 12'h000) begin
            n_fail++; $display("FAIL reset_dut1: got %h required 000", {v1, pe1, fe1, b1, d1});
        end
        n_checks++;
        if ({v2, pe2, fe2, b2, d2} !== 11'h000) begin
            n_fail++; $display("FAIL reset_dut2: got %h required 000", {v2, pe2, fe2, b2, d2});
        end
        // Line held low across reset release must not start a frame
        drive(0, 1'b0);
        @(negedge clk) rst = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (b0 !== 1'b0) begin n_fail++; $display("FAIL low_at_release_busy: got %b required 0", b0); end
        n_checks++;
        if (q0.size() != 0) begin n_fail++; $display("FAIL low_at_release_valid: got %0d pulses required 0", q0.size()); end
        idle_bits(0, 3);
    endtask

    task automatic test_basic();
        logic [10:0] ev, exp;
        clear_q(0);
        exp = model(9'h0A5, 8, 0, 1'b0, 2'b11, 1);
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1);
        drive(0, 1'b1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (b0 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b required 0", b0); end
        n_checks++;
        if (last_valid0 - t_drop != 10 * (1 + 8 + 1)) begin
            n_fail++; $display("FAIL basic_latency: got %0d cycles required %0d", last_valid0 - t_drop, 100);
        end
        idle_bits(0, 2);
        n_checks++;
        if (q0.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d required 1", q0.size()); end
        pop_ev(0, ev);
        n_checks++;
        if (ev !== exp) begin n_fail++; $display("FAIL basic_word: got %h required %h", ev, exp); end
    endtask

    task automatic test_parity();
        logic [10:0] ev, exp;
        for (int k = 0; k < 2; k++) begin
            logic pbit;
            pbit = (k == 0) ? 1'b1 : 1'b0;
            clear_q(1);
            exp = model(9'h037, 8, 2, pbit, 2'b11, 1);
            send_frame(1, 9'h037, 8, 2, pbit, 2'b11, 1);
            idle_bits(1, 2);
            n_checks++;
            if (q1.size() != 1) begin n_fail++; $display("FAIL parity_count_%0d: got %0d required 1", k, q1.size()); end
            pop_ev(1, ev);
            n_checks++;
            if (ev !== exp) begin n_fail++; $display("FAIL parity_word_%0d: got %h required %h", k, ev, exp); end
        end
    endtask

    task automatic test_glitch();
        logic [10:0] ev, exp;
        clear_q(0);
        drive(0, 1'b0);
        repeat (3) @(negedge clk);
        drive(0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (b0 !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b required 1", b0); end
        repeat (6) @(negedge clk);
        n_checks++;
        if (b0 !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_clear: got %b required 0", b0); end
        idle_bits(0, 2);
        n_checks++;
        if (q0.size() != 0) begin n_fail++; $display("FAIL glitch_no_valid: got %0d required 0", q0.size()); end
        exp = model(9'h03C, 8, 0, 1'b0, 2'b11, 1);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1);
        idle_bits(0, 2);
        pop_ev(0, ev);
        n_checks++;
        if (ev !== exp) begin n_fail++; $display("FAIL glitch_next_word: got %h required %h", ev, exp); end
    endtask

    task automatic test_break();
        logic [10:0] ev, exp;
        clear_q(0);
        exp = model(9'h055, 8, 0, 1'b0, 2'b00, 1);
        send_frame(0, 9'h055, 8, 0, 1'b0, 2'b00, 1);
        repeat (30) bit_wait();
        n_checks++;
        if (b0 !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b required 1", b0); end
        idle_bits(0, 2);
        n_checks++;
        if (q0.size() != 1) begin n_fail++; $display("FAIL break_count: got %0d required 1", q0.size()); end
        pop_ev(0, ev);
        n_checks++;
        if (ev !== exp) begin n_fail++; $display("FAIL break_word: got %h required %h", ev, exp); end
        exp = model(9'h081, 8, 0, 1'b0, 2'b11, 1);
        send_frame(0, 9'h081, 8, 0, 1'b0, 2'b11, 1);
        idle_bits(0, 2);
        pop_ev(0, ev);
        n_checks++;
        if (ev !== exp) begin n_fail++; $display("FAIL break_next_word: got %h required %h", ev, exp); end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] ev, exp;
        logic [8:0] data;
        data = 9'h05A;
        clear_q(0);
        drive(0, 1'b0); bit_wait();
        for (int i = 0; i < 3; i++) begin drive(0, data[i]); bit_wait(); end
        drive(0, data[3]);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({v0, pe0, fe0, b0, d0} !== 12'h000) begin
            n_fail++; $display("FAIL midframe_reset_outputs: got %h required 000", {v0, pe0, fe0, b0, d0});
        end
        @(negedge clk);
        drive(0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_bits(0, 3);
        n_checks++;
        if (q0.size() != 0) begin n_fail++; $display("FAIL midframe_no_valid: got %0d required 0", q0.size()); end
        exp = model(data, 8, 0, 1'b0, 2'b11, 1);
        send_frame(0, data, 8, 0, 1'b0, 2'b11, 1);
        idle_bits(0, 2);
        pop_ev(0, ev);
        n_checks++;
        if (ev !== exp) begin n_fail++; $display("FAIL midframe_next_word: got %h required %h", ev, exp); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] ev;
        logic [10:0] exp_q[$];
        logic [8:0]  words[2];
        logic [1:0]  stops;
        words[0] = 9'h000;
        words[1] = 9'h07F;
        for (int pass = 0; pass < 2; pass++) begin
            stops = (pass == 0) ? 2'b11 : 2'b01;
            clear_q(2);
            exp_q.delete();
            for (int k = 0; k < 2; k++) begin
                exp_q.push_back(model(words[k], 7, 1, good_par(words[k], 7, 1), stops, 2));
                send_frame(2, words[k], 7, 1, good_par(words[k], 7, 1), stops, 2);
                if (pass == 1) idle_bits(2, 2);
            end
            idle_bits(2, 2);
            n_checks++;
            if (q2.size() != 2) begin n_fail++; $display("FAIL b2b_count_%0d: got %0d required 2", pass, q2.size()); end
            for (int k = 0; k < 2; k++) begin
                pop_ev(2, ev);
                n_checks++;
                if (ev !== exp_q[k]) begin
                    n_fail++; $display("FAIL b2b_word_%0d_%0d: got %h required %h", pass, k, ev, exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] ev;
        logic [10:0] exp_q[$];
        logic [8:0]  data;
        logic        pbit;
        logic [1:0]  stops;
        int nbits, pmode, nstop, gap, got;
        for (int w = 0; w < 3; w++) begin
            nbits = (w == 2) ? 7 : 8;
            pmode = (w == 0) ? 0 : ((w == 1) ? 2 : 1);
            nstop = (w == 2) ? 2 : 1;
            clear_q(w);
            exp_q.delete();
            for (int k = 0; k < 24; k++) begin
                data  = 9'($urandom);
                pbit  = good_par(data, nbits, pmode) ^ ($urandom_range(0, 3) == 0);
                stops = 2'b11;
                if ($urandom_range(0, 3) == 0) stops[$urandom_range(0, nstop - 1)] = 1'b0;
                exp_q.push_back(model(data, nbits, pmode, pbit, stops, nstop));
                send_frame(w, data, nbits, pmode, pbit, stops, nstop);
                gap = (stops != 2'b11) ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
                idle_bits(w, gap);
            end
            idle_bits(w, 2);
            got = q_size(w);
            n_checks++;
            if (got != exp_q.size()) begin
                n_fail++; $display("FAIL random_count_dut%0d: got %0d required %0d", w, got, exp_q.size());
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                pop_ev(w, ev);
                n_checks++;
                if (ev !== exp_q[k]) begin
                    n_fail++; $display("FAIL random_word_dut%0d_%0d: got %h required %h", w, k, ev, exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rxd = 3'b111;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
